// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   ID-stage branch/jump resolution. Compares branch operands in ID (with
//   ALU forwarding from MEM). Drives the PC next-address mux controls and
//   stalls or flushes the front end. Keeps saturating performance counters.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   ID_*                          decoded ID instruction, operands, PC+4
//   EX_* / MEM_*                  producer info used for hazard and forwarding
//   beq_mux, bne_mux, ID_Jump     taken redirects (combinational)
//   ID_target, ID_Jaddress        branch / jump targets (combinational)
//   PC_write, IF_ID_write         0 freezes PC and IF/ID
//   IF_ID_flush, ID_EX_bubble     kill wrong-path fetch / insert NOP
//   branch_cnt, taken_cnt, stall_cnt   16-bit saturating counters

// Per-source-operand hazard detection and operand forwarding.
// This module is instantiated once for rs and once for rt.
module branch_resolve_src (
  input  logic [4:0]  src,
  input  logic [31:0] rf_data,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rd,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_rd,
  input  logic [31:0] MEM_alu_result,
  output logic        ex_alu_hit,
  output logic        ex_load_hit,
  output logic        mem_load_hit,
  output logic [31:0] opnd
);
  logic ex_match, mem_match;

  // $0 is hardwired, so a producer writing $0 never creates a dependency.
  assign ex_match     = (src != 5'd0) && (src == EX_rd)  && EX_RegWrite;
  assign mem_match    = (src != 5'd0) && (src == MEM_rd) && MEM_RegWrite;
  assign ex_alu_hit   = ex_match & ~EX_MemRead;
  assign ex_load_hit  = ex_match &  EX_MemRead;
  assign mem_load_hit = mem_match & MEM_MemRead;

  // The register file writes in the first half-cycle, so WB needs no bypass.
  assign opnd = (mem_match && !MEM_MemRead) ? MEM_alu_result : rf_data;
endmodule

module branch_resolve_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ID_valid,
  input  logic        ID_Branch_eq,
  input  logic        ID_Branch_ne,
  input  logic        ID_J,
  input  logic [31:0] ID_PC_plus4,
  input  logic [31:0] ID_imm,
  input  logic [25:0] ID_instr_index,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [31:0] ID_rs_data,
  input  logic [31:0] ID_rt_data,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rd,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_rd,
  input  logic [31:0] MEM_alu_result,
  output logic        beq_mux,
  output logic        bne_mux,
  output logic        ID_Jump,
  output logic [31:0] ID_target,
  output logic [31:0] ID_Jaddress,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt,
  output logic [15:0] stall_cnt
);
  localparam int NSRC = 2;

  localparam logic [0:0] S_RESOLVE = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  logic [0:0] state;
  logic [1:0] hold;

  // Index 0 is rs and index 1 is rt.
  logic [NSRC-1:0][4:0]  src;
  logic [NSRC-1:0][31:0] rf_data;
  logic [NSRC-1:0][31:0] opnd;
  logic [NSRC-1:0]       ex_alu_hit, ex_load_hit, mem_load_hit;

  assign src     = {ID_rt, ID_rs};
  assign rf_data = {ID_rt_data, ID_rs_data};

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      branch_resolve_src u_src (
        .src            (src[g]),
        .rf_data        (rf_data[g]),
        .EX_RegWrite    (EX_RegWrite),
        .EX_MemRead     (EX_MemRead),
        .EX_rd          (EX_rd),
        .MEM_RegWrite   (MEM_RegWrite),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_rd         (MEM_rd),
        .MEM_alu_result (MEM_alu_result),
        .ex_alu_hit     (ex_alu_hit[g]),
        .ex_load_hit    (ex_load_hit[g]),
        .mem_load_hit   (mem_load_hit[g]),
        .opnd           (opnd[g])
      );
    end
  endgenerate

  // Targets are computed every cycle, whether or not they are used.
  assign ID_target   = ID_PC_plus4 + {ID_imm[29:0], 2'b00};
  assign ID_Jaddress = {ID_PC_plus4[31:28], ID_instr_index, 2'b00};

  // When a branch flag is set, it takes priority over J.
  // When both branch flags are set, the instruction resolves as beq.
  logic any_br, branch_v, jump_v;
  assign any_br   = ID_Branch_eq | ID_Branch_ne;
  assign branch_v = ID_valid & any_br;
  assign jump_v   = ID_valid & ID_J & ~any_br;

  // Stall cycles still required before the branch operands are usable.
  // An EX producer is younger than a MEM producer, so an EX match decides
  // the count first.
  logic [1:0] need;
  always_comb begin
    need = 2'd0;
    if (|ex_load_hit)
      need = 2'd2;
    else if (|ex_alu_hit || |mem_load_hit)
      need = 2'd1;
  end

  logic in_resolve, stall, resolve, opnd_eq;
  assign in_resolve = (state == S_RESOLVE);
  assign stall      = !in_resolve || (branch_v && need != 2'd0);
  assign resolve    = in_resolve && branch_v && need == 2'd0;
  assign opnd_eq    = (opnd[0] == opnd[1]);

  assign beq_mux      = resolve && ID_Branch_eq && opnd_eq;
  assign bne_mux      = resolve && !ID_Branch_eq && ID_Branch_ne && !opnd_eq;
  assign ID_Jump      = in_resolve && jump_v;
  assign IF_ID_flush  = beq_mux | bne_mux | ID_Jump;
  assign PC_write     = ~stall;
  assign IF_ID_write  = ~stall;
  assign ID_EX_bubble = stall;

  // A stall with one cycle needed stays in RESOLVE and re-evaluates
  // the hazard, because the producer has moved down the pipe by then.
  // HOLD covers the additional load-use cycles and ignores the ID inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESOLVE;
      hold  <= 2'd0;
    end else if (in_resolve) begin
      if (branch_v && need != 2'd0) begin
        hold  <= need - 2'd1;
        state <= (need > 2'd1) ? S_HOLD : S_RESOLVE;
      end
    end else begin
      hold <= (hold != 2'd0) ? hold - 2'd1 : 2'd0;
      if (hold <= 2'd1)
        state <= S_RESOLVE;
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      branch_cnt <= sat_inc(branch_cnt, resolve);
      taken_cnt  <= sat_inc(taken_cnt, IF_ID_flush);
      stall_cnt  <= sat_inc(stall_cnt, stall);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit. For each cycle, the stimulus
// pushes its expected control outputs. The checker pops and compares them
// on the falling edge.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ID_valid, ID_Branch_eq, ID_Branch_ne, ID_J;
  logic [31:0] ID_PC_plus4, ID_imm, ID_rs_data, ID_rt_data, MEM_alu_result;
  logic [25:0] ID_instr_index;
  logic [4:0]  ID_rs, ID_rt, EX_rd, MEM_rd;
  logic        EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;
  logic        beq_mux, bne_mux, ID_Jump, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
  logic [31:0] ID_target, ID_Jaddress;
  logic [15:0] branch_cnt, taken_cnt, stall_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .reset_n(reset_n),
    .ID_valid(ID_valid), .ID_Branch_eq(ID_Branch_eq), .ID_Branch_ne(ID_Branch_ne), .ID_J(ID_J),
    .ID_PC_plus4(ID_PC_plus4), .ID_imm(ID_imm), .ID_instr_index(ID_instr_index),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_rd(MEM_rd),
    .MEM_alu_result(MEM_alu_result),
    .beq_mux(beq_mux), .bne_mux(bne_mux), .ID_Jump(ID_Jump),
    .ID_target(ID_target), .ID_Jaddress(ID_Jaddress),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string       name;
    logic        beq, bne, jmp, stall;
    logic        tchk;
    logic [31:0] tgt, jad;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic b, input logic ne, input logic j,
                              input logic s);
    exp_t e;
    e.name = n; e.beq = b; e.bne = ne; e.jmp = j; e.stall = s;
    e.tchk = 1'b0; e.tgt = '0; e.jad = '0;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    chk({e.name, ".beq"},   {31'd0, beq_mux},      {31'd0, e.beq});
    chk({e.name, ".bne"},   {31'd0, bne_mux},      {31'd0, e.bne});
    chk({e.name, ".jump"},  {31'd0, ID_Jump},      {31'd0, e.jmp});
    chk({e.name, ".flush"}, {31'd0, IF_ID_flush},  {31'd0, e.beq | e.bne | e.jmp});
    chk({e.name, ".pcw"},   {31'd0, PC_write},     {31'd0, ~e.stall});
    chk({e.name, ".ifw"},   {31'd0, IF_ID_write},  {31'd0, ~e.stall});
    chk({e.name, ".bub"},   {31'd0, ID_EX_bubble}, {31'd0, e.stall});
    if (e.tchk) begin
      chk({e.name, ".target"}, ID_target,   e.tgt);
      chk({e.name, ".jaddr"},  ID_Jaddress, e.jad);
    end
  endtask

  // Each call covers one clock cycle. The inputs were set after the previous
  // rising edge, and the outputs are checked on the falling edge.
  task automatic cyc(input exp_t e);
    q.push_back(e);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  task automatic cnts(input string tag, input int b, input int t, input int s);
    chk({tag, ".branch_cnt"}, {16'd0, branch_cnt}, b);
    chk({tag, ".taken_cnt"},  {16'd0, taken_cnt},  t);
    chk({tag, ".stall_cnt"},  {16'd0, stall_cnt},  s);
  endtask

  task automatic idle();
    ID_valid = 0; ID_Branch_eq = 0; ID_Branch_ne = 0; ID_J = 0;
    ID_PC_plus4 = 0; ID_imm = 0; ID_instr_index = 0;
    ID_rs = 0; ID_rt = 0; ID_rs_data = 0; ID_rt_data = 0;
    EX_RegWrite = 0; EX_MemRead = 0; EX_rd = 0;
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_rd = 0; MEM_alu_result = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    #12;
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  exp_t e;

  initial begin
    idle();
    reset_n = 0;
    #3;
    cnts("reset", 0, 0, 0);
    do_reset();
    cyc(mk("reset_idle", 0, 0, 0, 0));

    // beq $0,$0. An EX writer of $0 must not create a hazard.
    ID_valid = 1; ID_Branch_eq = 1; ID_PC_plus4 = 32'h10; ID_imm = 32'h3;
    EX_RegWrite = 1; EX_MemRead = 1; EX_rd = 0;
    e = mk("beq_r0", 1, 0, 0, 0); e.tchk = 1; e.tgt = 32'h1C; e.jad = 32'h0;
    cyc(e);
    cnts("beq_r0", 1, 1, 0);

    // bne $8,$0, with a load to $8 in EX. Expect 2 stalls, then taken (5 != 0).
    idle();
    ID_valid = 1; ID_Branch_ne = 1; ID_rs = 8; ID_rs_data = 32'h5;
    ID_PC_plus4 = 32'h100; ID_imm = 32'hFFFF_FFFF;
    EX_RegWrite = 1; EX_MemRead = 1; EX_rd = 8;
    cyc(mk("ldex_s1", 0, 0, 0, 1));
    EX_RegWrite = 0; EX_MemRead = 0; EX_rd = 0;
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_rd = 8;
    cyc(mk("ldex_s2", 0, 0, 0, 1));
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_rd = 0;
    e = mk("ldex_res", 0, 1, 0, 0); e.tchk = 1; e.tgt = 32'hFC; e.jad = 32'h0;
    cyc(e);
    cnts("ldex", 2, 2, 2);

    // beq $9,$10 with a MEM ALU forward of 5 (rf value 7) against rt=5.
    idle();
    ID_valid = 1; ID_Branch_eq = 1; ID_rs = 9; ID_rt = 10;
    ID_rs_data = 32'h7; ID_rt_data = 32'h5;
    MEM_RegWrite = 1; MEM_rd = 9; MEM_alu_result = 32'h5;
    cyc(mk("memfwd_taken", 1, 0, 0, 0));
    MEM_alu_result = 32'h6;
    cyc(mk("memfwd_nt", 0, 0, 0, 0));
    cnts("memfwd", 4, 3, 2);

    // ALU producer in EX: 1 stall, then the forward from MEM resolves it.
    MEM_RegWrite = 0; MEM_rd = 0;
    EX_RegWrite = 1; EX_rd = 9;
    cyc(mk("exalu_s1", 0, 0, 0, 1));
    EX_RegWrite = 0; EX_rd = 0;
    MEM_RegWrite = 1; MEM_rd = 9; MEM_alu_result = 32'h5;
    cyc(mk("exalu_res", 1, 0, 0, 0));
    cnts("exalu", 5, 4, 3);

    // Load in MEM, on rt: 1 stall, then the register file supplies the value.
    idle();
    ID_valid = 1; ID_Branch_eq = 1; ID_rs = 3; ID_rt = 9;
    ID_rs_data = 32'h5; ID_rt_data = 32'h5;
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_rd = 9; MEM_alu_result = 32'h1;
    cyc(mk("ldmem_s1", 0, 0, 0, 1));
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_rd = 0;
    cyc(mk("ldmem_res", 1, 0, 0, 0));
    cnts("ldmem", 6, 5, 4);

    // Jump. A load-use match on rs must not cause a stall.
    idle();
    ID_valid = 1; ID_J = 1; ID_instr_index = 26'h40; ID_PC_plus4 = 32'h1000_0004;
    ID_rs = 8; EX_RegWrite = 1; EX_MemRead = 1; EX_rd = 8;
    e = mk("jump", 0, 0, 1, 0); e.tchk = 1; e.tgt = 32'h1000_0004; e.jad = 32'h1000_0100;
    cyc(e);
    cnts("jump", 6, 6, 4);

    // beq with J set: the branch wins.
    idle();
    ID_valid = 1; ID_Branch_eq = 1; ID_J = 1;
    cyc(mk("beq_over_j", 1, 0, 0, 0));
    // eq and ne both set, operands unequal: resolves as beq, so not taken.
    ID_J = 0; ID_Branch_ne = 1; ID_rs = 1; ID_rt = 2; ID_rs_data = 1; ID_rt_data = 2;
    cyc(mk("eqne_nt", 0, 0, 0, 0));
    cnts("prio", 8, 7, 4);

    // Bubble in ID with a hazard present: no effect on outputs or counters.
    ID_valid = 0; EX_RegWrite = 1; EX_MemRead = 1; EX_rd = 1;
    cyc(mk("bubble", 0, 0, 0, 0));
    cnts("bubble", 8, 7, 4);

    // Assert reset while in HOLD during a load-use stall.
    idle();
    ID_valid = 1; ID_Branch_ne = 1; ID_rs = 8; ID_rs_data = 32'h5;
    EX_RegWrite = 1; EX_MemRead = 1; EX_rd = 8;
    cyc(mk("rst_s1", 0, 0, 0, 1));
    idle();
    ID_valid = 1; ID_Branch_eq = 1;   // clean beq $0,$0: HOLD must ignore it
    q.push_back(mk("rst_hold", 0, 0, 0, 1));
    @(negedge clk);
    compare_head();
    #1 reset_n = 0;
    #1;
    chk("rst_mid.pcw",   {31'd0, PC_write},     32'd1);
    chk("rst_mid.bub",   {31'd0, ID_EX_bubble}, 32'd0);
    chk("rst_mid.beq",   {31'd0, beq_mux},      32'd1);
    chk("rst_mid.flush", {31'd0, IF_ID_flush},  32'd1);
    cnts("rst_mid", 0, 0, 0);
    #1 reset_n = 1;
    @(posedge clk);
    #1;
    cnts("rst_after", 1, 1, 0);
    cyc(mk("rst_beq", 1, 0, 0, 0));
    cnts("rst_beq", 2, 2, 0);

    // taken_cnt saturation: run 0xFFFE taken jumps, then 2 more.
    idle();
    do_reset();
    ID_valid = 1; ID_J = 1;
    for (int i = 0; i < 32'hFFFE; i++) @(posedge clk);
    #1;
    cnts("sat_pre", 0, 32'hFFFE, 0);
    cyc(mk("sat_j1", 0, 0, 1, 0));
    cnts("sat_1", 0, 32'hFFFF, 0);
    cyc(mk("sat_j2", 0, 0, 1, 0));
    cnts("sat_2", 0, 32'hFFFF, 0);

    chk("scoreboard_left", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch/jump resolution unit that generates the redirect controls consumed by the PC next-address multiplexer: `beq_mux`, `bne_mux`, `ID_Jump`, `ID_target` and `ID_Jaddress`. It compares branch operands in ID with forwarding from MEM. It stalls IF/ID for data hazards on branch operands, flushes the wrong-path fetch on any redirect, and keeps saturating performance counters.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ID_valid`  in  1  ID holds a real instruction; 0 means a bubble.
- `ID_Branch_eq`, `ID_Branch_ne`, `ID_J`  in  1 each  decoded beq / bne / j.
- `ID_PC_plus4`  in  32  PC+4 of the ID instruction.
- `ID_imm`  in  32  sign-extended 16-bit offset.
- `ID_instr_index`  in  26  j-format target field.
- `ID_rs`, `ID_rt`  in  5 each  source register numbers.
- `ID_rs_data`, `ID_rt_data`  in  32 each  register-file read data. The register file writes in the first half-cycle, so WB needs no bypass.
- `EX_RegWrite`, `EX_MemRead`  in  1 each.
- `EX_rd`  in  5.
- `MEM_RegWrite`, `MEM_MemRead`  in  1 each.
- `MEM_rd`  in  5.
- `MEM_alu_result`  in  32.
- `beq_mux`, `bne_mux`, `ID_Jump`  out  1 each  taken redirects.
- `ID_target`  out  32  branch target.
- `ID_Jaddress`  out  32  jump target.
- `PC_write`  out  1  0 freezes the PC register.
- `IF_ID_write`  out  1  0 holds the IF/ID register.
- `IF_ID_flush`  out  1  1 zeroes IF/ID on the next edge.
- `ID_EX_bubble`  out  1  1 inserts a NOP into ID/EX.
- `branch_cnt`, `taken_cnt`, `stall_cnt`  out  16 each  performance counters.

## Operation
- Targets are combinational and computed every cycle:
  - `ID_target` = `ID_PC_plus4` + (`ID_imm` << 2), 32-bit, wraps modulo 2^32.
  - `ID_Jaddress` = {`ID_PC_plus4`[31:28], `ID_instr_index`, 2'b00}.
- Priority:
  - If a branch flag and `ID_J` are both set, the branch wins and the jump is ignored.
  - If both branch flags are set, it is treated as beq.
- Hazard requirement N is evaluated only for a valid branch. Jumps never stall. A source register matches a producer when the numbers are equal and the register is nonzero; both rs and rt are checked.
  - EX match with `EX_RegWrite` and `EX_MemRead`: N=2.
  - EX match with `EX_RegWrite`, no `EX_MemRead`: N=1.
  - MEM match with `MEM_RegWrite` and `MEM_MemRead`: N=1.
  - Otherwise N=0.
- Operand select: a MEM match with `MEM_RegWrite` and no `MEM_MemRead` takes `MEM_alu_result`; otherwise the register-file data is used.
- FSM, two states:
  - RESOLVE, with N>0: stall this cycle; load 2-bit `hold` = N-1; go to HOLD if N-1>0, else stay in RESOLVE (re-evaluate next cycle).
  - RESOLVE, with N=0: resolve; beq is taken when the operands are equal, bne when they differ.
  - HOLD: stall; decrement `hold`; return to RESOLVE when `hold` reaches 0.
- Stall cycle outputs:
  - `PC_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1.
  - All redirect outputs 0, `IF_ID_flush`=0.
- Resolve cycle outputs:
  - `PC_write`=1, `IF_ID_write`=1, `ID_EX_bubble`=0.
  - Taken redirect: the matching redirect output =1 and `IF_ID_flush`=1.
  - Not-taken branch: no redirect, no flush.
- A valid jump in RESOLVE asserts `ID_Jump`=1 and `IF_ID_flush`=1.
- `ID_valid`=0 in RESOLVE means no stall, no redirect, no flush.
- Counters are 16-bit and saturate at 0xFFFF (no wrap):
  - `branch_cnt` increments on each resolved branch.
  - `taken_cnt` increments on each taken branch or jump.
  - `stall_cnt` increments on each stall cycle.

## Timing
- Redirect, flush and stall outputs are combinational from inputs and state, and are valid before the same rising edge at which the PC register and IF/ID latch.
- Branch redirect latency:
  - No hazard: 0 stall cycles.
  - ALU producer in EX: 1 stall cycle.
  - Load in EX: 2 stall cycles.
  - Load in MEM: 1 stall cycle.
- Reset (asynchronous, `reset_n`=0):
  - State goes to RESOLVE, `hold`=0, all counters 0.
  - Outputs settle to their RESOLVE-state combinational values.
  - Reset asserted mid-HOLD aborts the stall immediately.
- On a counter saturation edge the counter holds 0xFFFF; other counters are unaffected.

## Test plan
- beq with rs=rt=$0, no hazard, PC+4=0x0000_0010, imm=0x0003:
  - Same cycle: `beq_mux`=1, `ID_target`=0x0000_001C, `IF_ID_flush`=1.
  - `branch_cnt` and `taken_cnt` each +1.
- bne on $8 with `EX_rd`=8, `EX_MemRead`=1:
  - Exactly 2 stall cycles (`PC_write`=0, `ID_EX_bubble`=1).
  - Third cycle resolves using the register-file data; `stall_cnt`=2.
- beq on $9 with the MEM ALU producer `MEM_alu_result`=0x5 and `ID_rt_data`=0x5 (register-file value 0x7):
  - 0 stalls, taken, because the forwarded value is used.
- j with `ID_instr_index`=0x0000040 and PC+4=0x1000_0004:
  - `ID_Jaddress`=0x1000_0100, `ID_Jump`=1, flush=1.
  - No stall even when `EX_rd` matches rs.
- `reset_n` pulsed low during the HOLD state of a load-use stall:
  - Outputs immediately leave stall; counters read 0; next branch resolves from RESOLVE.
- `taken_cnt` preloaded to 0xFFFE via 2 extra taken jumps:
  - Reads 0xFFFF and stays at 0xFFFF.
